bus_arbiter2: RTL and testbench



---
 rtl/bus_if_types_pkg.sv | 15 +
 rtl/bus_arbiter2.sv | 129 ++++++++++++
 tb/tb_bus_arbiter2.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_if_types_pkg.sv
// Bus transaction field types shared by rv_core, the bus arbiter and slave fabric.
package bus_if_types_pkg;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } ttype_e;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_e;

endpackage

// File: rtl/bus_arbiter2.sv
// Two-master round-robin arbiter sharing one slave port between ibus (m0) and dbus (m1).
// One transaction is granted at a time; completion is routed back only to its owner.
module bus_arbiter2
  import bus_if_types_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_bstart,
  input  ttype_e      m0_ttype,
  input  tsize_e      m0_tsize,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_bdone,
  input  logic        m1_bstart,
  input  ttype_e      m1_ttype,
  input  tsize_e      m1_tsize,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_bdone,
  output logic        s_breq,
  output logic        s_bstart,
  output ttype_e      s_ttype,
  output tsize_e      s_tsize,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_bdone,
  output logic [1:0]  gnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  state_e state;
  logic   prio;

  // On completion the finishing master is excluded from the next pick, so a
  // bstart still high in its bdone cycle is never re-granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 2'b00;
      prio  <= RESET_PRIO;
    end else begin
      case (state)
        IDLE: begin
          if (m0_bstart && (!m1_bstart || !prio)) begin
            state <= BUSY0;
            gnt   <= 2'b01;
            prio  <= 1'b1;
          end else if (m1_bstart) begin
            state <= BUSY1;
            gnt   <= 2'b10;
            prio  <= 1'b0;
          end
        end
        BUSY0: begin
          if (s_bdone) begin
            if (m1_bstart) begin
              state <= BUSY1;
              gnt   <= 2'b10;
              prio  <= 1'b0;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end else if (!m0_bstart) begin
            state <= IDLE;
            gnt   <= 2'b00;
          end
        end
        BUSY1: begin
          if (s_bdone) begin
            if (m0_bstart) begin
              state <= BUSY0;
              gnt   <= 2'b01;
              prio  <= 1'b1;
            end else begin
              state <= IDLE;
              gnt   <= 2'b00;
            end
          end else if (!m1_bstart) begin
            state <= IDLE;
            gnt   <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
        end
      endcase
    end
  end

  always_comb begin
    s_bstart = 1'b0;
    s_ttype  = READ;
    s_tsize  = WORD;
    s_addr   = 32'd0;
    s_wdata  = 32'd0;
    if (gnt[0]) begin
      s_bstart = m0_bstart;
      s_ttype  = m0_ttype;
      s_tsize  = m0_tsize;
      s_addr   = m0_addr;
      s_wdata  = m0_wdata;
    end else if (gnt[1]) begin
      s_bstart = m1_bstart;
      s_ttype  = m1_ttype;
      s_tsize  = m1_tsize;
      s_addr   = m1_addr;
      s_wdata  = m1_wdata;
    end
  end

  assign s_breq   = |gnt;
  assign m0_bdone = gnt[0] & s_bdone;
  assign m1_bdone = gnt[1] & s_bdone;
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Randomized and directed bench for bus_arbiter2 against an ownership/priority reference model.
module tb_bus_arbiter2;
  import bus_if_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bst[2];
  ttype_e      tt[2];
  tsize_e      ts[2];
  logic [31:0] addr[2];
  logic [31:0] wdat[2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_bdone, m1_bdone;
  logic        s_breq, s_bstart;
  ttype_e      s_ttype;
  tsize_e      s_tsize;
  logic [31:0] s_addr, s_wdata;
  logic [31:0] s_rdata = 32'd0;
  logic        s_bdone = 1'b0;
  logic [1:0]  gnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the slave (-1 = nobody) and which master is preferred.
  int owner = -1;
  int prio  = 1;
  bit exp_done[2];

  always #5 clk = ~clk;

  bus_arbiter2 #(.RESET_PRIO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_bstart(bst[0]), .m0_ttype(tt[0]), .m0_tsize(ts[0]), .m0_addr(addr[0]),
    .m0_wdata(wdat[0]), .m0_rdata(m0_rdata), .m0_bdone(m0_bdone),
    .m1_bstart(bst[1]), .m1_ttype(tt[1]), .m1_tsize(ts[1]), .m1_addr(addr[1]),
    .m1_wdata(wdat[1]), .m1_rdata(m1_rdata), .m1_bdone(m1_bdone),
    .s_breq(s_breq), .s_bstart(s_bstart), .s_ttype(s_ttype), .s_tsize(s_tsize),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone),
    .gnt(gnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    prio  = 1;
  endtask

  task automatic check_all();
    logic [1:0] eg;
    eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    for (int i = 0; i < 2; i++) exp_done[i] = (owner == i) && s_bdone;
    check("gnt", gnt, eg);
    check("s_breq", s_breq, owner >= 0);
    check("s_bstart", s_bstart, (owner >= 0) ? bst[owner] : 1'b0);
    check("s_ttype", s_ttype, (owner >= 0) ? tt[owner] : READ);
    check("s_tsize", s_tsize, (owner >= 0) ? ts[owner] : WORD);
    check("s_addr", s_addr, (owner >= 0) ? addr[owner] : 32'd0);
    check("s_wdata", s_wdata, (owner >= 0) ? wdat[owner] : 32'd0);
    check("m0_bdone", m0_bdone, exp_done[0]);
    check("m1_bdone", m1_bdone, exp_done[1]);
    if (exp_done[0]) check("m0_rdata", m0_rdata, s_rdata);
    if (exp_done[1]) check("m1_rdata", m1_rdata, s_rdata);
  endtask

  // Arbitration rules applied at each rising edge to the inputs of that cycle.
  task automatic model_step();
    int y;
    if (owner < 0) begin
      if (bst[0] && bst[1]) owner = prio;
      else if (bst[0]) owner = 0;
      else if (bst[1]) owner = 1;
      if (owner >= 0) prio = 1 - owner;
    end else if (s_bdone) begin
      y = 1 - owner;
      if (bst[y]) begin
        prio  = owner;
        owner = y;
      end else begin
        owner = -1;
      end
    end else if (!bst[owner]) begin
      owner = -1;
    end
  endtask

  task automatic settle();
    #1;
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic new_fields(input int i);
    tt[i]   = ttype_e'($urandom_range(1));
    ts[i]   = tsize_e'($urandom_range(2));
    addr[i] = $urandom;
    wdat[i] = $urandom;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      bst[i] = 1'b0; tt[i] = READ; ts[i] = WORD; addr[i] = 32'd0; wdat[i] = 32'd0;
    end
    s_bdone = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int wait_cnt, max_wait, m1_req, m1_done, busy_cnt;
  logic [1:0] last_gnt;

  initial begin
    idle_inputs();
    @(negedge clk);
    #1;
    check("rst_gnt", gnt, 2'b00);
    check("rst_s_bstart", s_bstart, 1'b0);
    check("rst_s_tsize", s_tsize, WORD);
    check("rst_m1_bdone", m1_bdone, 1'b0);
    do_reset();

    // Single m1 write, slave completes 3 cycles after the grant.
    bst[1] = 1'b1; addr[1] = 32'h100; tt[1] = WRITE; wdat[1] = 32'hDEADBEEF;
    settle(); advance();
    settle();
    check("single_gnt", gnt, 2'b10);
    check("single_addr", s_addr, 32'h100);
    check("single_wdata", s_wdata, 32'hDEADBEEF);
    advance(); settle(); advance();
    s_bdone = 1'b1; s_rdata = 32'h1234_5678;
    settle();
    check("single_m1_done", m1_bdone, 1'b1);
    check("single_m0_done", m0_bdone, 1'b0);
    advance();
    bst[1] = 1'b0; s_bdone = 1'b0;
    settle();
    check("single_idle", gnt, 2'b00);
    advance();

    // Contention straight from reset: m1 first, then m0 with no gap.
    do_reset();
    bst[0] = 1'b1; addr[0] = 32'h40; bst[1] = 1'b1; addr[1] = 32'h80;
    settle(); advance();
    settle();
    check("cont_first", gnt, 2'b10);
    s_bdone = 1'b1;
    settle(); advance();
    bst[1] = 1'b0; s_bdone = 1'b0;
    settle();
    check("cont_handoff", gnt, 2'b01);
    check("cont_handoff_bstart", s_bstart, 1'b1);
    s_bdone = 1'b1;
    settle(); advance();
    bst[1] = 1'b1; s_bdone = 1'b0;
    settle(); advance();
    settle();
    check("cont_prio_m1", gnt, 2'b10);
    bst[0] = 1'b0; s_bdone = 1'b1;
    settle(); advance();

    // Stale request: m1 holds bstart through and after its completion cycle.
    s_bdone = 1'b0;
    settle();
    check("stale_idle", gnt, 2'b00);
    check("stale_s_bstart", s_bstart, 1'b0);
    advance();
    settle();
    check("stale_regrant", gnt, 2'b10);
    bst[1] = 1'b0;
    settle(); advance();

    // Abandon: m0 drops its request, then a late bdone must be ignored.
    bst[0] = 1'b1; addr[0] = 32'hC0;
    settle(); advance();
    settle();
    check("abandon_gnt", gnt, 2'b01);
    bst[0] = 1'b0;
    settle(); advance();
    s_bdone = 1'b1;
    settle();
    check("abandon_idle", gnt, 2'b00);
    check("abandon_m0_done", m0_bdone, 1'b0);
    check("abandon_m1_done", m1_bdone, 1'b0);
    advance();
    s_bdone = 1'b0;

    // Reset while m0 owns the slave: outputs drop without a clock edge.
    bst[0] = 1'b1; s_bdone = 1'b0;
    settle(); advance();
    s_bdone = 1'b1;
    settle();
    check("mid_pre_m0_done", m0_bdone, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_gnt", gnt, 2'b00);
    check("mid_rst_s_bstart", s_bstart, 1'b0);
    check("mid_rst_m0_done", m0_bdone, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; s_bdone = 1'b0; bst[1] = 1'b1;
    settle(); advance();
    settle();
    check("mid_post_prio", gnt, 2'b10);
    bst[0] = 1'b0; bst[1] = 1'b0;
    settle(); advance();
    settle(); advance();

    // Continuous ibus with dbus requesting every 10 cycles; slave takes 3 cycles.
    bst[0] = 1'b1;
    max_wait = 0; wait_cnt = 0; m1_req = 0; m1_done = 0; busy_cnt = 0; last_gnt = 2'b00;
    for (int c = 0; c < 1000; c++) begin
      if (gnt != last_gnt) busy_cnt = 0;
      last_gnt = gnt;
      if (exp_done[0]) new_fields(0);
      if (exp_done[1]) bst[1] = 1'b0;
      if (c % 10 == 0 && !bst[1]) begin
        bst[1] = 1'b1; new_fields(1); m1_req++; wait_cnt = 0;
      end
      s_bdone = (gnt != 2'b00) && (busy_cnt == 2);
      s_rdata = $urandom;
      busy_cnt++;
      settle();
      if (exp_done[1]) m1_done++;
      if (bst[1] && owner != 1) wait_cnt++;
      if (wait_cnt > max_wait) max_wait = wait_cnt;
      advance();
    end
    check("fair_max_wait_le4", max_wait <= 4, 1'b1);
    check("fair_no_starve", m1_done >= m1_req - 1, 1'b1);
    idle_inputs();
    settle(); advance();
    settle(); advance();

    // Random masters and slave, including idle-time bdone and abandons.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (bst[i] && exp_done[i]) begin
          bst[i] = ($urandom_range(1) == 1);
          if (bst[i]) new_fields(i);
        end else if (bst[i] && $urandom_range(99) < 3) begin
          bst[i] = 1'b0;
        end else if (!bst[i] && $urandom_range(99) < 30) begin
          bst[i] = 1'b1;
          new_fields(i);
        end
      end
      s_bdone = ($urandom_range(99) < 30);
      s_rdata = $urandom;
      settle();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
